adpll_gain_scheduler: RTL and testbench
=======================================

# adpll_gain_scheduler

Gear-shift controller for the ADPLL loop filter. It sequences the filter's proportional and integral gains: high gains during acquisition, low gains once the phase error stays small. It also asserts lock, clears the filter integrator on (re)acquisition, and falls back to acquisition on sustained error. It sits between the phase detector error bus and the loop filter's `kp_i`, `ki_i` and `reset_i` inputs, with the loop filter in dynamic-gain mode.

## Interface
- Clock is `gen_clk_i`. Reset is `reset_n_i`, asynchronous and active-low.
- ERROR_WIDTH, 8, width of signed phase error.
- KP_WIDTH, 3, width of proportional gain word.
- KI_WIDTH, 4, width of integral gain word.
- KP_ACQ, 3'b100, proportional gain during acquisition.
- KI_ACQ, 4'b0100, integral gain during acquisition.
- KP_TRK, 3'b001, proportional gain during settle and track.
- KI_TRK, 4'b0001, integral gain during settle and track.
- LOCK_THRESH, 4, in-window limit: |error| <= LOCK_THRESH.
- LOCK_COUNT, 16, consecutive in-window samples needed to leave ACQUIRE (>=1).
- SETTLE_CYCLES, 8, dwell time in SETTLE (>=1).
- UNLOCK_COUNT, 4, consecutive out-of-window samples in TRACK that cause loss of lock (>=1).
- CNT_WIDTH, 8, counter width; must hold max(LOCK_COUNT, SETTLE_CYCLES, UNLOCK_COUNT).
- gen_clk_i  in  1  loop clock
- reset_n_i  in  1  async active-low reset
- enable_i  in  1  run request; low forces IDLE
- error_i  in  ERROR_WIDTH  signed phase error from the detector
- kp_o  out  KP_WIDTH  proportional gain to the loop filter
- ki_o  out  KI_WIDTH  integral gain to the loop filter
- lf_reset_o  out  1  active-high clear for the loop filter
- locked_o  out  1  lock indicator
- state_o  out  2  current state: IDLE=0, ACQUIRE=1, SETTLE=2, TRACK=3

## Operation
- In-window test: compute |error_i| at ERROR_WIDTH+1 bits, so the most negative value -2^(ERROR_WIDTH-1) gives +2^(ERROR_WIDTH-1) with no overflow. The sample is in-window when |error_i| <= LOCK_THRESH.
- **IDLE:** kp_o=KP_ACQ, ki_o=KI_ACQ, lf_reset_o=1, locked_o=0. Moves to ACQUIRE when enable_i=1.
- **ACQUIRE:** keeps the ACQ gains. A single counter counts consecutive in-window samples; any out-of-window sample clears it to 0.
  - When the sample that makes the count equal LOCK_COUNT is taken, move to SETTLE and clear the counter.
- **SETTLE:** TRK gains; error_i is ignored. Counts SETTLE_CYCLES cycles, then moves to TRACK.
- **TRACK:** TRK gains, locked_o=1. The counter counts consecutive out-of-window samples; any in-window sample clears it.
  - When the count reaches UNLOCK_COUNT, move to ACQUIRE with the ACQ gains and locked_o=0.
  - lf_reset_o=1 for exactly the first cycle of that ACQUIRE.
- enable_i=0 in any state moves to IDLE on the next edge and clears the counter. This has priority over all other transitions.
- Counters saturate; they never wrap.

## Timing
- All outputs are registered and change together with the state on the same edge.
- Reset values: state IDLE, kp_o=KP_ACQ, ki_o=KI_ACQ, lf_reset_o=1, locked_o=0, state_o=0, counter 0.
- error_i is sampled at every rising edge. There is no internal input register; the detector output is already registered.
- Lock latency is LOCK_COUNT + SETTLE_CYCLES edges after entry to ACQUIRE, given error_i is continuously in-window.
- Unlock latency is UNLOCK_COUNT edges.
- Reset assertion mid-operation returns every output to its reset value immediately (asynchronous). Release takes effect on the next edge.

## Configuration
- `ADPLL_GAIN_SCHED_LOSS_FLAG_EN` defined:
  - Adds output `lock_lost_o` (1 bit). It is set on the TRACK→ACQUIRE transition edge.
  - It stays set (sticky) until the state is IDLE. Its reset value is 0.
- Macro undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Package `adpll_ctrl_pkg` holds the 2-bit state type and encodings (IDLE/ACQUIRE/SETTLE/TRACK).
- Sub-module `error_window_detect`: combinational absolute value and threshold compare. It takes error_i and LOCK_THRESH and produces the in_window flag.
- The state machine, the shared counter and the output registers stay in the top level.

## Test plan
1. **Reset:** reset_n_i=0 mid-TRACK → outputs immediately kp_o=3'b100, ki_o=4'b0100, lf_reset_o=1, locked_o=0, state_o=0.
2. **Clean acquisition:** enable_i=1, error_i=2 constant.
   - state_o=1 after edge 0; state_o=2 after edge 16 with kp_o=3'b001 and ki_o=4'b0001.
   - locked_o=1 and state_o=3 after edge 24.
3. **Broken streak:** in ACQUIRE feed 15 samples at error_i=-4, then 1 at error_i=5, then 16 at error_i=0.
   - SETTLE is reached only after the 32nd sample.
   - Confirms -4 counts as in-window and 5 as out-of-window.
4. **Loss of lock:** in TRACK feed error_i=-128 for 4 samples.
   - state_o=1, locked_o=0, ACQ gains, and a one-cycle lf_reset_o pulse.
   - With the macro: lock_lost_o=1, held until enable_i=0.
5. **Glitch tolerance:** in TRACK feed 3 samples at error_i=20, then 1 at error_i=0, repeated 10 times → stays in TRACK, locked_o=1 throughout.
6. **Disable:** enable_i=0 during SETTLE → state_o=0 and lf_reset_o=1 on the next edge. Re-enabling restarts the full LOCK_COUNT count.

Source files
------------

// File: rtl/adpll_gain_scheduler_pkg.sv
// Shared state encoding for the ADPLL gain scheduler.
// The encoding is visible on state_o, so the values are fixed.
package adpll_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_TRACK   = 2'd3
  } state_e;

  // IDLE and ACQUIRE run the loop filter with the wide-bandwidth gains.
  function automatic logic uses_acq_gains(input state_e s);
    return (s == ST_IDLE) || (s == ST_ACQUIRE);
  endfunction

endpackage

// File: rtl/adpll_gain_scheduler_error_window_detect.sv
// Combinational |error| <= LOCK_THRESH test. The magnitude is one bit wider than
// the error, so the most negative error maps to its true positive magnitude.
module error_window_detect
  import adpll_ctrl_pkg::*;
#(
  parameter int unsigned ERROR_WIDTH = 8,
  parameter int unsigned LOCK_THRESH = 4
) (
  input  logic [ERROR_WIDTH-1:0] error_i,
  output logic                   in_window_o
);

  logic [ERROR_WIDTH:0] ext;
  logic [ERROR_WIDTH:0] mag;

  always_comb begin
    ext = {error_i[ERROR_WIDTH-1], error_i};
    mag = ext;
    if (ext[ERROR_WIDTH]) begin
      mag = ~ext + {{ERROR_WIDTH{1'b0}}, 1'b1};
    end
    in_window_o = (mag <= (ERROR_WIDTH+1)'(LOCK_THRESH));
  end

endmodule

// File: rtl/adpll_gain_scheduler.sv
// Loop-filter gear-shift controller: IDLE -> ACQUIRE -> SETTLE -> TRACK with a shared
// saturating counter. Optional sticky lock_lost_o when ADPLL_GAIN_SCHED_LOSS_FLAG_EN is defined.
module adpll_gain_scheduler
  import adpll_ctrl_pkg::*;
#(
  parameter int unsigned         ERROR_WIDTH   = 8,
  parameter int unsigned         KP_WIDTH      = 3,
  parameter int unsigned         KI_WIDTH      = 4,
  parameter logic [KP_WIDTH-1:0] KP_ACQ        = 3'b100,
  parameter logic [KI_WIDTH-1:0] KI_ACQ        = 4'b0100,
  parameter logic [KP_WIDTH-1:0] KP_TRK        = 3'b001,
  parameter logic [KI_WIDTH-1:0] KI_TRK        = 4'b0001,
  parameter int unsigned         LOCK_THRESH   = 4,
  parameter int unsigned         LOCK_COUNT    = 16,
  parameter int unsigned         SETTLE_CYCLES = 8,
  parameter int unsigned         UNLOCK_COUNT  = 4,
  parameter int unsigned         CNT_WIDTH     = 8
) (
  input  logic                   gen_clk_i,
  input  logic                   reset_n_i,
  input  logic                   enable_i,
  input  logic [ERROR_WIDTH-1:0] error_i,
  output logic [KP_WIDTH-1:0]    kp_o,
  output logic [KI_WIDTH-1:0]    ki_o,
  output logic                   lf_reset_o,
  output logic                   locked_o,
  output logic [1:0]             state_o
`ifdef ADPLL_GAIN_SCHED_LOSS_FLAG_EN
  ,
  output logic                   lock_lost_o
`endif
);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [KP_WIDTH-1:0]   kp_q, kp_d;
  logic [KI_WIDTH-1:0]   ki_q, ki_d;
  logic                  lf_reset_q, lf_reset_d;
  logic                  locked_q, locked_d;
  logic                  in_window;

  error_window_detect #(
    .ERROR_WIDTH (ERROR_WIDTH),
    .LOCK_THRESH (LOCK_THRESH)
  ) u_window (
    .error_i     (error_i),
    .in_window_o (in_window)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lf_reset_d = 1'b0;
    cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);

    if (!enable_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQUIRE;
          cnt_d   = '0;
        end
        ST_ACQUIRE: begin
          if (!in_window) begin
            cnt_d = '0;
          end else if (cnt_inc == CNT_WIDTH'(LOCK_COUNT)) begin
            state_d = ST_SETTLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_SETTLE: begin
          if (cnt_inc == CNT_WIDTH'(SETTLE_CYCLES)) begin
            state_d = ST_TRACK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_TRACK: begin
          if (in_window) begin
            cnt_d = '0;
          end else if (cnt_inc == CNT_WIDTH'(UNLOCK_COUNT)) begin
            // Re-acquisition: clear the integrator for the first ACQUIRE cycle only.
            state_d    = ST_ACQUIRE;
            cnt_d      = '0;
            lf_reset_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are computed from the next state so they change on the same edge.
    if (state_d == ST_IDLE) begin
      lf_reset_d = 1'b1;
    end
    kp_d     = uses_acq_gains(state_d) ? KP_ACQ : KP_TRK;
    ki_d     = uses_acq_gains(state_d) ? KI_ACQ : KI_TRK;
    locked_d = (state_d == ST_TRACK);
  end

  always_ff @(posedge gen_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      kp_q       <= KP_ACQ;
      ki_q       <= KI_ACQ;
      lf_reset_q <= 1'b1;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      kp_q       <= kp_d;
      ki_q       <= ki_d;
      lf_reset_q <= lf_reset_d;
      locked_q   <= locked_d;
    end
  end

  assign kp_o       = kp_q;
  assign ki_o       = ki_q;
  assign lf_reset_o = lf_reset_q;
  assign locked_o   = locked_q;
  assign state_o    = state_q;

`ifdef ADPLL_GAIN_SCHED_LOSS_FLAG_EN
  logic lock_lost_q, lock_lost_d;

  always_comb begin
    lock_lost_d = lock_lost_q;
    if (state_d == ST_IDLE) begin
      lock_lost_d = 1'b0;
    end else if ((state_q == ST_TRACK) && (state_d == ST_ACQUIRE)) begin
      lock_lost_d = 1'b1;
    end
  end

  always_ff @(posedge gen_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lock_lost_q <= 1'b0;
    end else begin
      lock_lost_q <= lock_lost_d;
    end
  end

  assign lock_lost_o = lock_lost_q;
`endif

endmodule

// File: tb/tb_adpll_gain_scheduler.sv
// Directed bench for adpll_gain_scheduler: a behavioural model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_adpll_gain_scheduler;

  logic       gen_clk_i = 1'b0;
  logic       reset_n_i;
  logic       enable_i;
  logic [7:0] error_i;
  logic [2:0] kp_o;
  logic [3:0] ki_o;
  logic       lf_reset_o;
  logic       locked_o;
  logic [1:0] state_o;
`ifdef ADPLL_GAIN_SCHED_LOSS_FLAG_EN
  logic       lock_lost_o;
`endif

  int checks   = 0;
  int failures = 0;

  adpll_gain_scheduler #(
    .ERROR_WIDTH   (8),
    .KP_WIDTH      (3),
    .KI_WIDTH      (4),
    .LOCK_THRESH   (4),
    .LOCK_COUNT    (16),
    .SETTLE_CYCLES (8),
    .UNLOCK_COUNT  (4),
    .CNT_WIDTH     (8)
  ) dut (
    .gen_clk_i  (gen_clk_i),
    .reset_n_i  (reset_n_i),
    .enable_i   (enable_i),
    .error_i    (error_i),
    .kp_o       (kp_o),
    .ki_o       (ki_o),
    .lf_reset_o (lf_reset_o),
    .locked_o   (locked_o),
    .state_o    (state_o)
`ifdef ADPLL_GAIN_SCHED_LOSS_FLAG_EN
    ,
    .lock_lost_o(lock_lost_o)
`endif
  );

  always #5 gen_clk_i = ~gen_clk_i;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode number plus three independent run lengths.
  int m_mode;       // 0 idle, 1 acquire, 2 settle, 3 track
  int m_good_run;   // consecutive in-window samples while acquiring
  int m_settle_age; // edges spent settling
  int m_bad_run;    // consecutive out-of-window samples while tracking
  bit m_clear;
  bit m_lost;

  function automatic bit in_win(input logic [7:0] e);
    int v;
    v = int'($signed(e));
    if (v < 0) v = -v;
    return v <= 4;
  endfunction

  always @(posedge gen_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      m_mode = 0; m_good_run = 0; m_settle_age = 0; m_bad_run = 0;
      m_clear = 1; m_lost = 0;
    end else if (!enable_i) begin
      m_mode = 0; m_good_run = 0; m_settle_age = 0; m_bad_run = 0;
      m_clear = 1; m_lost = 0;
    end else begin
      m_clear = 0;
      if (m_mode == 0) begin
        m_mode = 1; m_good_run = 0;
      end else if (m_mode == 1) begin
        m_good_run = in_win(error_i) ? m_good_run + 1 : 0;
        if (m_good_run == 16) begin m_mode = 2; m_settle_age = 0; end
      end else if (m_mode == 2) begin
        m_settle_age++;
        if (m_settle_age == 8) begin m_mode = 3; m_bad_run = 0; end
      end else begin
        m_bad_run = in_win(error_i) ? 0 : m_bad_run + 1;
        if (m_bad_run == 4) begin
          m_mode = 1; m_good_run = 0; m_clear = 1; m_lost = 1;
        end
      end
    end
  end

  always @(negedge gen_clk_i) begin
    if (reset_n_i) begin
      check("model_state", int'(state_o), m_mode);
      check("model_kp", int'(kp_o), (m_mode <= 1) ? 4 : 1);
      check("model_ki", int'(ki_o), (m_mode <= 1) ? 4 : 1);
      check("model_lf_reset", int'(lf_reset_o), int'(m_clear));
      check("model_locked", int'(locked_o), (m_mode == 3) ? 1 : 0);
`ifdef ADPLL_GAIN_SCHED_LOSS_FLAG_EN
      check("model_lock_lost", int'(lock_lost_o), int'(m_lost));
`endif
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge gen_clk_i);
      #1;
    end
  endtask

  task automatic feed(input logic [7:0] e, input int n);
    error_i = e;
    tick(n);
  endtask

  initial begin
    reset_n_i = 1'b0;
    enable_i  = 1'b0;
    error_i   = 8'd0;
    #12;
    check("rst_state", int'(state_o), 0);
    check("rst_kp", int'(kp_o), 4);
    check("rst_ki", int'(ki_o), 4);
    check("rst_lf_reset", int'(lf_reset_o), 1);
    check("rst_locked", int'(locked_o), 0);
    @(posedge gen_clk_i); #1;
    reset_n_i = 1'b1;
    tick(2);
    check("idle_hold_state", int'(state_o), 0);

    // Clean acquisition with error=2.
    enable_i = 1'b1;
    feed(8'd2, 1);
    check("acq_edge0_state", int'(state_o), 1);
    tick(15);
    check("acq_edge15_state", int'(state_o), 1);
    tick(1);
    check("acq_edge16_state", int'(state_o), 2);
    check("acq_edge16_kp", int'(kp_o), 1);
    check("acq_edge16_ki", int'(ki_o), 1);
    tick(7);
    check("settle_edge23_locked", int'(locked_o), 0);
    tick(1);
    check("track_edge24_state", int'(state_o), 3);
    check("track_edge24_locked", int'(locked_o), 1);

    // Glitch tolerance: 3 bad then 1 good, ten times.
    for (int r = 0; r < 10; r++) begin
      feed(8'd20, 3);
      check("glitch_state", int'(state_o), 3);
      feed(8'd0, 1);
      check("glitch_locked", int'(locked_o), 1);
    end

    // Loss of lock with the most negative error.
    feed(8'h80, 3);
    check("loss_pre_state", int'(state_o), 3);
    feed(8'h80, 1);
    check("loss_state", int'(state_o), 1);
    check("loss_locked", int'(locked_o), 0);
    check("loss_kp", int'(kp_o), 4);
    check("loss_lf_reset", int'(lf_reset_o), 1);
`ifdef ADPLL_GAIN_SCHED_LOSS_FLAG_EN
    check("loss_flag", int'(lock_lost_o), 1);
`endif
    feed(8'h80, 1);
    check("loss_lf_reset_end", int'(lf_reset_o), 0);

    // Broken streak: 15 x -4, one 5, then 16 x 0.
    feed(8'hFC, 15);
    check("streak_after_m4", int'(state_o), 1);
    feed(8'd5, 1);
    check("streak_after_5", int'(state_o), 1);
    feed(8'd0, 15);
    check("streak_after_31", int'(state_o), 1);
    feed(8'd0, 1);
    check("streak_after_32", int'(state_o), 2);
`ifdef ADPLL_GAIN_SCHED_LOSS_FLAG_EN
    check("flag_sticky", int'(lock_lost_o), 1);
`endif

    // Disable during SETTLE, then a full re-acquisition.
    tick(3);
    enable_i = 1'b0;
    tick(1);
    check("dis_state", int'(state_o), 0);
    check("dis_lf_reset", int'(lf_reset_o), 1);
`ifdef ADPLL_GAIN_SCHED_LOSS_FLAG_EN
    check("dis_flag", int'(lock_lost_o), 0);
`endif
    enable_i = 1'b1;
    feed(8'd0, 1);
    check("reen_state", int'(state_o), 1);
    tick(15);
    check("reen_edge15", int'(state_o), 1);
    tick(1);
    check("reen_edge16", int'(state_o), 2);
    tick(8);
    check("reen_track", int'(state_o), 3);

    // Asynchronous reset mid-TRACK.
    #3 reset_n_i = 1'b0;
    #1;
    check("async_state", int'(state_o), 0);
    check("async_kp", int'(kp_o), 4);
    check("async_ki", int'(ki_o), 4);
    check("async_lf_reset", int'(lf_reset_o), 1);
    check("async_locked", int'(locked_o), 0);
    @(posedge gen_clk_i); #1;
    reset_n_i = 1'b1;
    tick(2);
    check("post_reset_state", int'(state_o), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
